// File: rtl/fir_bank_pkg.sv
// Shared definitions for the multi-mode FIR engine.
//  - fir_state_e : FSM state encoding (idle / multiply-accumulate / round-and-output)
//  - mode_w      : width of the mode index for a given number of modes (at least 1)
//  - tap_w       : width of the tap index / history pointer
//  - acc_w       : accumulator width, sized so a full-length sum cannot overflow
//  - round_const : round-half-up constant added before the output shift
package fir_bank_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StRound
  } fir_state_e;

  function automatic int unsigned mode_w(input int unsigned num_modes);
    return (num_modes > 1) ? $clog2(num_modes) : 1;
  endfunction

  function automatic int unsigned tap_w(input int unsigned taps);
    return $clog2(taps);
  endfunction

  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned coeff_w,
                                        input int unsigned taps);
    return data_w + coeff_w + tap_w(taps);
  endfunction

  function automatic logic [63:0] round_const(input int unsigned shift);
    return 64'd1 << (shift - 1);
  endfunction

endpackage

// File: rtl/fir_bank_control_if.sv
// Sample / coefficient-ROM / result bundle of the FIR engine.
//  mode, ready, audio_in : sample source side (mode sampled only on accepted ready)
//  coeff_addr, coeff_data: combinational coefficient ROM lookup, {mode, tap} addressing
//  audio_out, done       : result held until the next one, done pulses on update
//  busy, overrun         : engine occupied / sample dropped because engine was occupied
// Modports: master = source + ROM side, slave = the FIR engine.
interface fir_bank_control_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned COEFF_W   = 10,
  parameter int unsigned TAPS      = 31,
  parameter int unsigned NUM_MODES = 4
) ();
  import fir_bank_pkg::*;

  localparam int unsigned MODE_W = mode_w(NUM_MODES);
  localparam int unsigned TAP_W  = tap_w(TAPS);

  logic        [MODE_W-1:0]       mode;
  logic                           ready;
  logic signed [DATA_W-1:0]       audio_in;
  logic        [MODE_W+TAP_W-1:0] coeff_addr;
  logic signed [COEFF_W-1:0]      coeff_data;
  logic signed [DATA_W-1:0]       audio_out;
  logic                           done;
  logic                           busy;
  logic                           overrun;

  modport master (
    output mode, ready, audio_in, coeff_data,
    input  coeff_addr, audio_out, done, busy, overrun
  );

  modport slave (
    input  mode, ready, audio_in, coeff_data,
    output coeff_addr, audio_out, done, busy, overrun
  );

endinterface

// File: rtl/fir_bank_mac.sv
// Signed multiply-accumulate used once per tap by the FIR engine.
//  clock, reset : rising-edge clock, asynchronous active-low reset
//  clear        : zero the accumulator (wins over enable)
//  enable       : acc += sample * coeff this cycle
//  sample, coeff: signed operands
//  acc          : registered signed accumulator
module fir_bank_mac #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned COEFF_W = 10,
  parameter int unsigned ACC_W   = 23
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      enable,
  input  logic signed [DATA_W-1:0]  sample,
  input  logic signed [COEFF_W-1:0] coeff,
  output logic signed [ACC_W-1:0]   acc
);

  localparam int unsigned ProdW = DATA_W + COEFF_W;

  logic signed [ProdW-1:0] product;
  logic signed [ACC_W-1:0] acc_q;

  assign product = ProdW'(sample) * ProdW'(coeff);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (enable) begin
      acc_q <= acc_q + ACC_W'(product);
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_bank_control.sv
// Multi-mode FIR engine: one shared sample history, one time-multiplexed MAC, coefficients
// from an external combinational ROM addressed by {mode, tap}. BYPASS_MODE forwards the input
// sample unchanged (still recorded in history). History survives mode changes.
//  clock, reset : rising-edge clock, asynchronous active-low reset clearing all state
//  bus (slave)  : mode/ready/audio_in in, coeff_addr out / coeff_data in,
//                 audio_out/done/busy/overrun out
// Build option: define FIR_BANK_SAT_EN to saturate the rounded result to DATA_W bits;
// otherwise the result is truncated (wraps).
module fir_bank_control
  import fir_bank_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned COEFF_W     = 10,
  parameter int unsigned TAPS        = 31,
  parameter int unsigned NUM_MODES   = 4,
  parameter int unsigned BYPASS_MODE = 3,
  parameter int unsigned OUT_SHIFT   = 10
) (
  input logic               clock,
  input logic               reset,
  fir_bank_control_if.slave bus
);

  localparam int unsigned MODE_W = mode_w(NUM_MODES);
  localparam int unsigned TAP_W  = tap_w(TAPS);
  localparam int unsigned ACC_W  = acc_w(DATA_W, COEFF_W, TAPS);

  localparam logic        [TAP_W-1:0]  LastTap   = TAP_W'(TAPS - 1);
  localparam logic        [TAP_W-1:0]  TapsMod   = TAP_W'(TAPS);
  localparam logic        [MODE_W-1:0] BypassIdx = MODE_W'(BYPASS_MODE);
  localparam logic signed [ACC_W-1:0]  RoundK    = ACC_W'(round_const(OUT_SHIFT));

  fir_state_e               state_q;
  logic signed [DATA_W-1:0] hist_q [TAPS];
  logic        [TAP_W-1:0]  wr_ptr_q;
  logic        [TAP_W-1:0]  tap_q;
  logic        [MODE_W-1:0] mode_q;
  logic signed [DATA_W-1:0] audio_out_q;
  logic                     done_q;
  logic                     busy_q;
  logic                     overrun_q;

  logic        [TAP_W-1:0]  rd_idx;
  logic        [MODE_W-1:0] mode_eff;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] result;
  logic                     mac_clear;
  logic                     mac_en;

  // Newest sample sits at wr_ptr; tap k reads k samples back, wrapping modulo TAPS.
  // The modulo-2^TAP_W add is exact because the final index is always below TAPS.
  always_comb begin
    rd_idx = wr_ptr_q - tap_q;
    if (wr_ptr_q < tap_q) begin
      rd_idx = wr_ptr_q + TapsMod - tap_q;
    end
  end

  always_comb begin
    mode_eff = bus.mode;
    if (32'(bus.mode) >= NUM_MODES) begin
      mode_eff = BypassIdx;
    end
  end

  assign mac_clear = (state_q == StIdle) && bus.ready;
  assign mac_en    = (state_q == StMac);

  fir_bank_mac #(
    .DATA_W (DATA_W),
    .COEFF_W(COEFF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clock (clock),
    .reset (reset),
    .clear (mac_clear),
    .enable(mac_en),
    .sample(hist_q[rd_idx]),
    .coeff (bus.coeff_data),
    .acc   (acc)
  );

`ifdef FIR_BANK_SAT_EN
  localparam logic signed [ACC_W-1:0] OutMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OutMin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] rounded;
  assign rounded = (acc + RoundK) >>> OUT_SHIFT;

  always_comb begin
    if (rounded > OutMax) begin
      result = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (rounded < OutMin) begin
      result = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      result = rounded[DATA_W-1:0];
    end
  end
`else
  assign result = DATA_W'((acc + RoundK) >>> OUT_SHIFT);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      tap_q       <= '0;
      mode_q      <= '0;
      audio_out_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      // Any ready outside IDLE (including the ROUND cycle) is dropped.
      overrun_q <= bus.ready && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (bus.ready) begin
            hist_q[wr_ptr_q] <= bus.audio_in;
            mode_q           <= mode_eff;
            tap_q            <= '0;
            busy_q           <= 1'b1;
            state_q          <= (mode_eff == BypassIdx) ? StRound : StMac;
          end
        end
        StMac: begin
          if (tap_q == LastTap) begin
            tap_q   <= '0;
            state_q <= StRound;
          end else begin
            tap_q <= tap_q + TAP_W'(1);
          end
        end
        StRound: begin
          // wr_ptr still points at the sample just accepted, so bypass reads it back here.
          audio_out_q <= (mode_q == BypassIdx) ? hist_q[wr_ptr_q] : result;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          wr_ptr_q    <= (wr_ptr_q == LastTap) ? '0 : wr_ptr_q + TAP_W'(1);
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.coeff_addr = {mode_q, tap_q};
  assign bus.audio_out  = audio_out_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_fir_bank_control.sv
// Directed bench for fir_bank_control. Two instances share clock, reset and stimulus:
// u_dut1 with OUT_SHIFT=1 and u_dut10 with OUT_SHIFT=10. Test ROM: mode0 coeff(k)=k+1,
// mode1 coeff=511, mode2 coeff(0)=1 else 0, mode3 bypass. Expected values are hand-computed.
module tb_fir_bank_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   out1;
  int   out10;

  always #5 clk = ~clk;

  fir_bank_control_if #(.DATA_W(8), .COEFF_W(10), .TAPS(31), .NUM_MODES(4)) bus1 ();
  fir_bank_control_if #(.DATA_W(8), .COEFF_W(10), .TAPS(31), .NUM_MODES(4)) bus10 ();

  fir_bank_control #(
    .DATA_W(8), .COEFF_W(10), .TAPS(31), .NUM_MODES(4), .BYPASS_MODE(3), .OUT_SHIFT(1)
  ) u_dut1 (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus1)
  );

  fir_bank_control #(
    .DATA_W(8), .COEFF_W(10), .TAPS(31), .NUM_MODES(4), .BYPASS_MODE(3), .OUT_SHIFT(10)
  ) u_dut10 (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus10)
  );

  function automatic logic signed [9:0] rom_coeff(input logic [6:0] addr);
    logic [4:0] tap;
    tap = addr[4:0];
    case (addr[6:5])
      2'd0:    return 10'(tap) + 10'sd1;
      2'd1:    return 10'sd511;
      2'd2:    return (tap == 5'd0) ? 10'sd1 : 10'sd0;
      default: return 10'sd0;
    endcase
  endfunction

  always_comb bus1.coeff_data  = rom_coeff(bus1.coeff_addr);
  always_comb bus10.coeff_data = rom_coeff(bus10.coeff_addr);

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic [1:0] m, input logic signed [7:0] s);
    bus1.ready     = rdy;
    bus1.mode      = m;
    bus1.audio_in  = s;
    bus10.ready    = rdy;
    bus10.mode     = m;
    bus10.audio_in = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One-cycle ready, then wait (bounded) for done; checks latency and busy, captures outputs.
  task automatic send_wait(input logic [1:0] m, input int s, input int exp_lat, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    drive(1'b1, m, 8'(s));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      drive(1'b0, m, 8'(s));
      if (lat == 1) check({tag, " busy"}, int'(bus1.busy), 1);
      if (bus1.done) seen = 1'b1;
    end
    check({tag, " latency"}, seen ? lat : -1, exp_lat);
    out1  = int'(bus1.audio_out);
    out10 = int'(bus10.audio_out);
  endtask

  initial begin
    int n;
    int ovr_cnt;
    int done_cnt;
    int done_lat;
    bit found;

    drive(1'b0, 2'd0, 8'sd0);
    #12;
    check("reset audio_out", int'(bus1.audio_out), 0);
    check("reset done", int'(bus1.done), 0);
    check("reset busy", int'(bus1.busy), 0);
    check("reset overrun", int'(bus1.overrun), 0);
    check("reset coeff_addr", int'(bus1.coeff_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Impulse of 2 through mode0 with shift 1 yields the coefficients 1..31, then 0.
    send_wait(2'd0, 2, 33, "imp0");
    check("imp out 0", out1, 1);
    for (int k = 1; k < 31; k++) begin
      send_wait(2'd0, 0, 33, "imp");
      check($sformatf("imp out %0d", k), out1, k + 1);
    end
    send_wait(2'd0, 0, 33, "imp tail");
    check("imp out tail", out1, 0);

    // DC overload: 31*127*511 = 2011807 -> shift10 1965 (wraps to -83), shift1 wraps to 80.
    do_reset();
    for (int k = 0; k < 31; k++) begin
      send_wait(2'd1, 127, 33, "dc");
    end
`ifdef FIR_BANK_SAT_EN
    check("dc out shift10", out10, 127);
    check("dc out shift1", out1, 127);
`else
    check("dc out shift10", out10, -83);
    check("dc out shift1", out1, 80);
`endif

    // Bypass writes history; the mode0 sample afterwards sees 7,6,5 behind it.
    do_reset();
    send_wait(2'd3, 5, 2, "byp5");
    check("byp out 5", out1, 5);
    send_wait(2'd3, 6, 2, "byp6");
    check("byp out 6", out1, 6);
    send_wait(2'd3, 7, 2, "byp7");
    check("byp out 7", out1, 7);
    check("byp out 7 shift10", out10, 7);
    send_wait(2'd0, 0, 33, "hist");
    check("history out", out1, 26);

    // Reset in the middle of the MAC phase.
    @(negedge clk);
    drive(1'b1, 2'd0, 8'sd2);
    n     = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      drive(1'b0, 2'd0, 8'sd0);
      if (bus1.coeff_addr[4:0] == 5'd15) found = 1'b1;
    end
    check("midmac reach tap15", found ? n : -1, 16);
    rst_n = 1'b0;
    #1;
    check("midmac audio_out", int'(bus1.audio_out), 0);
    check("midmac busy", int'(bus1.busy), 0);
    check("midmac coeff_addr", int'(bus1.coeff_addr), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus1.done) done_cnt++;
    end
    check("midmac no done", done_cnt, 0);
    send_wait(2'd0, 2, 33, "clean0");
    check("clean out 0", out1, 1);
    send_wait(2'd0, 0, 33, "clean1");
    check("clean out 1", out1, 2);

    // Overrun: second ready (with a mode change) at cycle 10 is dropped.
    do_reset();
    @(negedge clk);
    drive(1'b1, 2'd0, 8'sd2);
    ovr_cnt  = 0;
    done_cnt = 0;
    done_lat = -1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 10) drive(1'b1, 2'd1, 8'sd50);
      else drive(1'b0, 2'd1, 8'sd0);
      if (bus1.overrun) ovr_cnt++;
      if (bus1.done) begin
        done_cnt++;
        done_lat = k;
      end
    end
    check("ovr pulses", ovr_cnt, 1);
    check("ovr dones", done_cnt, 1);
    check("ovr done latency", done_lat, 33);
    check("ovr out", int'(bus1.audio_out), 1);
    send_wait(2'd0, 0, 33, "ovr next");
    check("ovr dropped sample", out1, 2);

    // Negative rounding.
    do_reset();
    send_wait(2'd2, -3, 33, "neg3");
    check("neg -3 out", out1, -1);
    do_reset();
    send_wait(2'd1, -128, 33, "neg128");
`ifdef FIR_BANK_SAT_EN
    check("neg -128 out", out1, -128);
`else
    check("neg -128 out", out1, 64);
`endif
    check("neg -128 shift10", out10, -64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
